// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Exception cause codes and the packed entry layout live here.
package inst_queue_pkg;

    localparam logic [6:0] EXCEPTION_INE  = 7'h0d;
    localparam logic [6:0] EXCEPTION_ADEF = 7'h08;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pc_exc;
        logic [6:0]  pc_cause;
        logic        ib_exc;
        logic [6:0]  ib_cause;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = 32 + 32 + 1 + 7 + 1 + 7;

    // What decode sees when nothing valid is presented.
    function automatic iq_entry_t iq_idle_entry();
        iq_entry_t e;
        e          = '0;
        e.pc_cause = EXCEPTION_INE;
        e.ib_cause = EXCEPTION_INE;
        return e;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch and decode handshake bundle of the instruction queue.
// slave = the queue itself; master = the fetch/decode environment driving it.
interface inst_queue_if;

    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_pc_exception;
    logic [6:0]  fetch_pc_exception_cause;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [1:0]  dec_is_exception;
    logic [6:0]  dec_pc_exception_cause;
    logic [6:0]  dec_instbuffer_exception_cause;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, fetch_pc_exception, fetch_pc_exception_cause,
        output fetch_ready,
        output dec_valid, dec_pc, dec_inst, dec_is_exception,
               dec_pc_exception_cause, dec_instbuffer_exception_cause,
        input  dec_ready
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, fetch_pc_exception, fetch_pc_exception_cause,
        input  fetch_ready,
        input  dec_valid, dec_pc, dec_inst, dec_is_exception,
               dec_pc_exception_cause, dec_instbuffer_exception_cause,
        output dec_ready
    );

endinterface

// File: rtl/inst_queue_tag.sv
// Combinational instbuffer-stage tagging of an incoming fetch entry:
// a misaligned pc without an earlier IF exception becomes an ADEF, else INE.
import inst_queue_pkg::*;

module inst_queue_tag (
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        pc_exc_i,
    input  logic [6:0]  pc_cause_i,
    output iq_entry_t   entry_o
);

    logic misaligned;

    assign misaligned = (pc_i[1:0] != 2'b00);

    always_comb begin
        entry_o          = '0;
        entry_o.pc       = pc_i;
        entry_o.inst     = inst_i;
        entry_o.pc_exc   = pc_exc_i;
        entry_o.pc_cause = pc_cause_i;
        // An IF exception already owns the entry; do not stack a second one on it.
        entry_o.ib_exc   = misaligned & ~pc_exc_i;
        entry_o.ib_cause = (misaligned & ~pc_exc_i) ? EXCEPTION_ADEF : EXCEPTION_INE;
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of tagged entries, head shown to decode.
// Define IBUF_BYPASS_EN for a zero-latency fetch->decode path when the queue is empty.
import inst_queue_pkg::*;

module inst_queue #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    inst_queue_if.slave   iq
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    iq_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    iq_entry_t in_entry;
    iq_entry_t head_entry;
    iq_entry_t dec_entry;
    logic      empty, full;
    logic      dec_valid;
    logic      push, pop, wr_en, rd_en;
    logic      bypass;

    inst_queue_tag u_tag (
        .pc_i       (iq.fetch_pc),
        .inst_i     (iq.fetch_inst),
        .pc_exc_i   (iq.fetch_pc_exception),
        .pc_cause_i (iq.fetch_pc_exception_cause),
        .entry_o    (in_entry)
    );

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign head_entry = mem_q[rd_ptr_q];

`ifdef IBUF_BYPASS_EN
    assign bypass = empty & ~flush & iq.fetch_valid & iq.dec_ready;
`else
    assign bypass = 1'b0;
`endif

    // Empty queue presents idle data rather than whatever slot rd_ptr points at.
    always_comb begin
        dec_entry = iq_idle_entry();
        dec_valid = 1'b0;
        if (!empty) begin
            dec_entry = head_entry;
            dec_valid = 1'b1;
        end else if (bypass) begin
            dec_entry = in_entry;
            dec_valid = 1'b1;
        end
    end

    // Ready depends only on registered occupancy, so a full queue refuses even while popping.
    assign iq.fetch_ready = ~full;

    assign push  = iq.fetch_valid & iq.fetch_ready;
    assign pop   = dec_valid & iq.dec_ready;
    assign wr_en = push & ~bypass;
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
            count_d  = count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only visible once counted as occupied.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign iq.dec_valid                      = dec_valid;
    assign iq.dec_pc                         = dec_entry.pc;
    assign iq.dec_inst                       = dec_entry.inst;
    assign iq.dec_is_exception               = {dec_entry.ib_exc, dec_entry.pc_exc};
    assign iq.dec_pc_exception_cause         = dec_entry.pc_cause;
    assign iq.dec_instbuffer_exception_cause = dec_entry.ib_cause;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, full+pop, tagging, flush and wrap.
import inst_queue_pkg::*;

module tb_inst_queue;

    logic clk;
    logic rst_n;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    inst_queue_if iq ();

    inst_queue #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .iq    (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc, input logic exc,
                             input logic [6:0] cause);
        iq.fetch_valid              = v;
        iq.fetch_pc                 = pc;
        iq.fetch_inst               = ~pc;
        iq.fetch_pc_exception       = exc;
        iq.fetch_pc_exception_cause = cause;
    endtask

    initial begin
        int accepted;
        flush        = 1'b0;
        iq.dec_ready = 1'b0;
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_dec_valid", 32'(iq.dec_valid), 32'h0);
        chk("rst_fetch_ready", 32'(iq.fetch_ready), 32'h1);
        chk("rst_dec_pc", iq.dec_pc, 32'h0);
        chk("rst_dec_inst", iq.dec_inst, 32'h0);
        chk("rst_is_exc", 32'(iq.dec_is_exception), 32'h0);
        chk("rst_pc_cause", 32'(iq.dec_pc_exception_cause), 32'(EXCEPTION_INE));
        chk("rst_ib_cause", 32'(iq.dec_instbuffer_exception_cause), 32'(EXCEPTION_INE));
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-stream with 3 entries queued
        for (int k = 0; k < 3; k++) begin
            set_fetch(1'b1, 32'h1c000100 + 32'(4 * k), 1'b0, 7'h0);
            tick();
        end
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("mid_pre_valid", 32'(iq.dec_valid), 32'h1);
        chk("mid_pre_count", 32'(dut.count_q), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(iq.dec_valid), 32'h0);
        chk("mid_rst_ready", 32'(iq.fetch_ready), 32'h1);
        chk("mid_rst_count", 32'(dut.count_q), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Fill with decode stalled: 10 offered, 8 accepted
        accepted = 0;
        for (int k = 0; k < 10; k++) begin
            set_fetch(1'b1, 32'h1c000000 + 32'(4 * k), 1'b0, 7'h0);
            chk($sformatf("fill_ready_%0d", k), 32'(iq.fetch_ready), (k < 8) ? 32'h1 : 32'h0);
            if (iq.fetch_ready) accepted++;
            tick();
        end
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("fill_accepted", 32'(accepted), 32'd8);
        chk("fill_count", 32'(dut.count_q), 32'd8);
        chk("stall_head_pc", iq.dec_pc, 32'h1c000000);

        // Drain in order
        iq.dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_valid_%0d", k), 32'(iq.dec_valid), 32'h1);
            chk($sformatf("drain_pc_%0d", k), iq.dec_pc, 32'h1c000000 + 32'(4 * k));
            chk($sformatf("drain_inst_%0d", k), iq.dec_inst, ~(32'h1c000000 + 32'(4 * k)));
            tick();
        end
        chk("drain_empty_valid", 32'(iq.dec_valid), 32'h0);
        chk("drain_empty_pc", iq.dec_pc, 32'h0);
        iq.dec_ready = 1'b0;

        // Full + simultaneous pop: push refused
        for (int k = 0; k < 8; k++) begin
            set_fetch(1'b1, 32'h1c001000 + 32'(4 * k), 1'b0, 7'h0);
            tick();
        end
        set_fetch(1'b1, 32'h1c002000, 1'b0, 7'h0);
        iq.dec_ready = 1'b1;
        chk("fullpop_ready", 32'(iq.fetch_ready), 32'h0);
        tick();
        chk("fullpop_count", 32'(dut.count_q), 32'd7);
        chk("fullpop_head", iq.dec_pc, 32'h1c001004);
        iq.dec_ready = 1'b0;
        chk("fullpop_ready_after", 32'(iq.fetch_ready), 32'h1);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("fullpop_push_count", 32'(dut.count_q), 32'd8);

        // Drain to 4, then flush with push+pop in the same cycle
        iq.dec_ready = 1'b1;
        repeat (4) tick();
        chk("preflush_count", 32'(dut.count_q), 32'd4);
        set_fetch(1'b1, 32'h1c003000, 1'b0, 7'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        iq.dec_ready = 1'b0;
        chk("flush_valid", 32'(iq.dec_valid), 32'h0);
        chk("flush_count", 32'(dut.count_q), 32'd0);
        chk("flush_pc", iq.dec_pc, 32'h0);
        chk("flush_ready", 32'(iq.fetch_ready), 32'h1);
        set_fetch(1'b1, 32'h1c004000, 1'b0, 7'h0);
        iq.dec_ready = 1'b1;
        #1;
`ifdef IBUF_BYPASS_EN
        chk("post_flush_byp_valid", 32'(iq.dec_valid), 32'h1);
        chk("post_flush_byp_pc", iq.dec_pc, 32'h1c004000);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("post_flush_byp_count", 32'(dut.count_q), 32'd0);
        chk("post_flush_byp_after", 32'(iq.dec_valid), 32'h0);
`else
        chk("post_flush_same_cycle", 32'(iq.dec_valid), 32'h0);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("post_flush_valid", 32'(iq.dec_valid), 32'h1);
        chk("post_flush_pc", iq.dec_pc, 32'h1c004000);
        tick();
        chk("post_flush_gone", 32'(iq.dec_valid), 32'h0);
`endif
        iq.dec_ready = 1'b0;
        tick();

        // Tagging
        set_fetch(1'b1, 32'h1c000002, 1'b0, 7'h11);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("tag_adef_exc", 32'(iq.dec_is_exception), 32'h2);
        chk("tag_adef_ib", 32'(iq.dec_instbuffer_exception_cause), 32'(EXCEPTION_ADEF));
        chk("tag_adef_pc", 32'(iq.dec_pc_exception_cause), 32'h11);
        iq.dec_ready = 1'b1;
        tick();
        iq.dec_ready = 1'b0;
        set_fetch(1'b1, 32'h1c000002, 1'b1, 7'h05);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("tag_ife_exc", 32'(iq.dec_is_exception), 32'h1);
        chk("tag_ife_pc", 32'(iq.dec_pc_exception_cause), 32'h05);
        chk("tag_ife_ib", 32'(iq.dec_instbuffer_exception_cause), 32'(EXCEPTION_INE));
        iq.dec_ready = 1'b1;
        tick();
        iq.dec_ready = 1'b0;
        set_fetch(1'b1, 32'h1c000008, 1'b0, 7'h0);
        tick();
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        chk("tag_ok_exc", 32'(iq.dec_is_exception), 32'h0);
        chk("tag_ok_ib", 32'(iq.dec_instbuffer_exception_cause), 32'(EXCEPTION_INE));
        iq.dec_ready = 1'b1;
        tick();
        iq.dec_ready = 1'b0;
        chk("tag_empty", 32'(iq.dec_valid), 32'h0);

        // Wrap: 20 push/pop pairs at one per cycle
        set_fetch(1'b1, 32'h1c010000, 1'b0, 7'h0);
        tick();
        iq.dec_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_fetch(k < 19, 32'h1c010000 + 32'(4 * (k + 1)), 1'b0, 7'h0);
            chk($sformatf("wrap_valid_%0d", k), 32'(iq.dec_valid), 32'h1);
            chk($sformatf("wrap_pc_%0d", k), iq.dec_pc, 32'h1c010000 + 32'(4 * k));
            chk($sformatf("wrap_inst_%0d", k), iq.dec_inst, ~(32'h1c010000 + 32'(4 * k)));
            tick();
        end
        set_fetch(1'b0, 32'h0, 1'b0, 7'h0);
        iq.dec_ready = 1'b0;
        chk("wrap_end_valid", 32'(iq.dec_valid), 32'h0);
        chk("wrap_end_count", 32'(dut.count_q), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
